// File: rtl/bitops_fair_arbiter_pkg.sv
// Shared bitops definitions: arbiter state encoding and the one-hot to
// binary encoder used by every block that reports a winning index.
package bitops_fair_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Widest one-hot vector the shared encoder accepts, and its index width.
  localparam int unsigned OH_MAX_W = 64;
  localparam int unsigned OH_IDX_W = 6;

  // OR of the indices of all set bits; exact for a one-hot (or zero) input.
  function automatic logic [OH_IDX_W-1:0] onehot_to_bin(input logic [OH_MAX_W-1:0] onehot);
    logic [OH_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < OH_MAX_W; i++) begin
      if (onehot[i]) idx |= OH_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bitops_get_hi.sv
// Highest-set-bit isolator: returns a one-hot copy of the top set bit of
// vec_i, or zero when vec_i is zero. Purely combinational.
module bitops_get_hi #(
  parameter int width = 8
) (
  input  logic [width-1:0] vec_i,
  output logic [width-1:0] hi_o
);

  // NOTE: hi_o gets a full default before the loop so every path assigns
  // it and no latch is inferred.
  always_comb begin
    hi_o = '0;
    for (int i = 0; i < width; i++) begin
      if (vec_i[i]) begin
        hi_o    = '0;
        hi_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bitops_fair_arbiter.sv
// Round-based fair arbiter: highest index first within a round, one grant per
// active requester per round, grant held until done or watchdog timeout.
module bitops_fair_arbiter
  import bitops_fair_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3,
  parameter int TMO   = 16,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  input  logic             done,
  output logic [WIDTH-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDXW-1:0]  gnt_idx,
  output logic             tmo_err
);

  localparam bit              WDOG_EN  = (TMO != 0);
  localparam logic [CNTW-1:0] CNT_LAST = (TMO == 0) ? '0 : CNTW'(TMO - 1);

  state_e            state_q;
  logic [WIDTH-1:0]  served_q;
  logic [WIDTH-1:0]  served_d;
  logic [CNTW-1:0]   cnt_q;
  logic [WIDTH-1:0]  gnt_q;
  logic              gnt_valid_q;
  logic [IDXW-1:0]   gnt_idx_q;
  logic              tmo_err_q;

  logic [WIDTH-1:0]  eff;
  logic [WIDTH-1:0]  cand;
  logic [WIDTH-1:0]  win;
  logic [IDXW-1:0]   win_idx;
  logic              new_round;

  // A round ends when no live requester is left unserved; stale served bits
  // of withdrawn requesters are masked out by the live req.
  assign eff       = req & ~served_q;
  assign new_round = (eff == '0);
  assign cand      = new_round ? req : eff;
  assign served_d  = new_round ? win : (served_q | win);
  assign win_idx   = IDXW'(onehot_to_bin(OH_MAX_W'(win)));

  bitops_get_hi #(
    .width (WIDTH)
  ) u_get_hi (
    .vec_i (cand),
    .hi_o  (win)
  );

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would make the update order depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      served_q    <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      tmo_err_q   <= 1'b0;
    end else begin
      tmo_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req != '0) begin
            state_q     <= ST_BUSY;
            gnt_q       <= win;
            gnt_valid_q <= 1'b1;
            gnt_idx_q   <= win_idx;
            cnt_q       <= '0;
            served_q    <= served_d;
          end
        end
        ST_BUSY: begin
          if (done) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
          end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            tmo_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_bitops_fair_arbiter.sv
// Self-checking bench: directed vector table, hand-written multi-cycle corner
// cases, then randomized traffic against a behavioural round-robin model.
module tb_bitops_fair_arbiter;

  localparam int WIDTH = 8;
  localparam int IDXW  = 3;
  localparam int TMO   = 16;
  localparam int CNTW  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] req;
  logic             done;
  logic [WIDTH-1:0] gnt;
  logic             gnt_valid;
  logic [IDXW-1:0]  gnt_idx;
  logic             tmo_err;

  int n_checks = 0;
  int n_fail   = 0;

  bitops_fair_arbiter #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW),
    .TMO   (TMO),
    .CNTW  (CNTW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] eg, input logic ev,
                           input logic [2:0] ei, input logic et);
    check({name, ".gnt"},       32'(gnt),       32'(eg));
    check({name, ".gnt_valid"}, 32'(gnt_valid), 32'(ev));
    check({name, ".gnt_idx"},   32'(gnt_idx),   32'(ei));
    check({name, ".tmo_err"},   32'(tmo_err),   32'(et));
  endtask

  // Apply inputs, let one rising edge sample them, then look 1 ns later.
  task automatic drive(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req   = '0;
    done  = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic void add_vec(input logic [7:0] r, input logic d, input logic [7:0] g,
                                  input logic [2:0] i, input logic v, input logic t);
    vec_t x;
    x.req = r; x.done = d; x.gnt = g; x.idx = i; x.valid = v; x.tmo = t;
    vecs.push_back(x);
  endfunction

  // Behavioural model: who is served this round, who owns the resource and
  // for how many cycles the grant has been visible.
  logic [7:0] m_served;
  logic       m_busy;
  int         m_owner;
  int         m_held;
  logic [2:0] m_idx;
  logic       m_tmo;

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_served = '0; m_busy = 1'b0; m_owner = 0; m_held = 0; m_idx = '0; m_tmo = 1'b0;
  endfunction

  function automatic void model_step(input logic [7:0] r, input logic d);
    int w;
    m_tmo = 1'b0;
    if (!m_busy) begin
      if (r != 8'h00) begin
        w = highest(r & ~m_served);
        if (w < 0) begin
          w = highest(r);
          m_served = '0;
        end
        m_served[w] = 1'b1;
        m_busy  = 1'b1;
        m_owner = w;
        m_idx   = 3'(w);
        m_held  = 1;
      end
    end else if (d) begin
      m_busy = 1'b0;
    end else if (TMO != 0 && m_held == TMO) begin
      m_busy = 1'b0;
      m_tmo  = 1'b1;
    end else begin
      m_held++;
    end
  endfunction

  initial begin
    int  vcnt;
    int  tcnt;
    bit  released;
    logic [7:0] r;
    logic       d;

    // Directed table: fairness over a full round and the restart, basic
    // two-requester sharing, idle done, and withdrawal during a grant.
    for (int k = 0; k < 8; k++) begin
      add_vec(8'hFF, 1'b0, 8'h80 >> k, 3'(7 - k), 1'b1, 1'b0);
      add_vec(8'hFF, 1'b1, 8'h00,      3'(7 - k), 1'b0, 1'b0);
    end
    add_vec(8'hFF, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
    add_vec(8'hFF, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0);
    add_vec(8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    add_vec(8'h24, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0);
    add_vec(8'h24, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    add_vec(8'h24, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
    add_vec(8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
    add_vec(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    add_vec(8'h00, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    add_vec(8'h00, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    add_vec(8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);

    // Reset with every requester active: outputs must stay quiet.
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].done);
      check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].valid, vecs[i].idx, vecs[i].tmo);
    end

    // Reset mid-grant drops the grant at once and clears the served mask.
    apply_reset();
    drive(8'h80, 1'b0);
    check_out("pre_rst_grant", 8'h80, 1'b1, 3'd7, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 8'h00, 1'b0, 3'd0, 1'b0);
    #2 rst_n = 1'b1;
    drive(8'h81, 1'b0);
    check_out("served_cleared", 8'h80, 1'b1, 3'd7, 1'b0);

    // Late joiner: bit 7 rejoins with bit 4 after being served this round.
    drive(8'h01, 1'b1);
    check_out("late_rel0", 8'h00, 1'b0, 3'd7, 1'b0);
    drive(8'h91, 1'b0);
    check_out("late_g4", 8'h10, 1'b1, 3'd4, 1'b0);
    drive(8'h91, 1'b1);
    drive(8'h91, 1'b0);
    check_out("late_g0", 8'h01, 1'b1, 3'd0, 1'b0);
    drive(8'h91, 1'b1);
    drive(8'h91, 1'b0);
    check_out("late_g7", 8'h80, 1'b1, 3'd7, 1'b0);
    drive(8'h00, 1'b1);

    // Watchdog: no done, grant visible exactly TMO cycles, single tmo_err.
    apply_reset();
    drive(8'h08, 1'b0);
    check_out("wd_grant", 8'h08, 1'b1, 3'd3, 1'b0);
    vcnt = 1;
    tcnt = 0;
    released = 1'b0;
    for (int i = 0; i < 40 && !released; i++) begin
      drive(8'h00, 1'b0);
      if (gnt_valid) vcnt++;
      else begin
        released = 1'b1;
        check("wd_tmo_on_release", 32'(tmo_err), 32'd1);
      end
      if (tmo_err) tcnt++;
    end
    check("wd_released", 32'(released), 32'd1);
    check("wd_valid_cycles", 32'(vcnt), 32'(TMO));
    drive(8'h00, 1'b0);
    if (tmo_err) tcnt++;
    check("wd_tmo_pulses", 32'(tcnt), 32'd1);

    // done on the last permitted cycle wins over the timeout.
    drive(8'h08, 1'b0);
    check_out("wd2_grant", 8'h08, 1'b1, 3'd3, 1'b0);
    vcnt = 1;
    for (int i = 0; i < TMO - 1; i++) begin
      drive(8'h00, 1'b0);
      if (gnt_valid) vcnt++;
    end
    check("wd2_held", 32'(vcnt), 32'(TMO));
    drive(8'h00, 1'b1);
    check_out("wd2_done", 8'h00, 1'b0, 3'd3, 1'b0);
    drive(8'h00, 1'b0);
    check("wd2_no_tmo", 32'(tmo_err), 32'd0);

    // Randomized traffic against the model; sparse done lets timeouts occur.
    apply_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      d = ($urandom_range(0, 11) == 0);
      drive(r, d);
      model_step(r, d);
      check_out($sformatf("rnd%0d", i), m_busy ? (8'h01 << m_owner) : 8'h00,
                m_busy, m_idx, m_tmo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitops_fair_arbiter.md
# bitops_fair_arbiter

Round-based fair arbiter that shares one synth resource (multiplier, wavetable port, envelope engine) among `WIDTH` requesters. Priority within a round is highest index first, using the `bitops_get_hi` highest-set-bit isolator. A served-mask guarantees every active requester one grant per round. A grant is held until the owner signals `done`; a watchdog forces release on timeout.

## Interface
- `WIDTH`, 8: number of requesters (≥2).
- `IDXW`, 3: width of `gnt_idx`; must satisfy 2^IDXW ≥ WIDTH.
- `TMO`, 16: maximum grant length in cycles; 0 disables the watchdog.
- `CNTW`, 16: watchdog counter width; TMO < 2^CNTW.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  WIDTH  level request per requester.
- `done`  in  1  owner releases the resource; sampled only in BUSY.
- `gnt`  out  WIDTH  one-hot grant, registered.
- `gnt_valid`  out  1  high while any grant is held.
- `gnt_idx`  out  IDXW  binary index of granted requester; holds last value when idle.
- `tmo_err`  out  1  one-cycle pulse when the watchdog forces release.

## Operation
- Internal state: `state` {IDLE, BUSY}, `served[WIDTH]`, `cnt[CNTW]`.
- Eligible set: `eff = req & ~served`. If `eff == 0` and `req != 0`, a new round starts: use `cand = req`, and `served` is reloaded with the winner only. Otherwise `cand = eff`, and `served |= winner`.
- Winner: `win = get_hi(cand)`, the highest set bit, one-hot.
- IDLE, `req == 0`: stay. Outputs and `served` unchanged.
- IDLE, `req != 0`: go to BUSY. Register `gnt <= win`, `gnt_valid <= 1`, `gnt_idx <= enc(win)`, `cnt <= 0`, and update `served`.
- BUSY: `gnt` is frozen regardless of `req`. Withdrawing a request does not revoke the grant.
  - `done == 1`: release. Next cycle `gnt = 0`, `gnt_valid = 0`, state IDLE.
  - `done == 0`, TMO≠0, `cnt == TMO-1`: forced release as above, plus `tmo_err = 1` for one cycle.
  - Otherwise: `cnt <= cnt + 1`.
- `done` and timeout in the same cycle: `done` wins, no `tmo_err`.
- `done` while IDLE is ignored.
- Requester bits set in `served` but since deasserted do not block round completion, because `eff` masks with the live `req`.

## Timing
- Reset (async assert, sync-free deassert): `gnt = 0`, `gnt_valid = 0`, `gnt_idx = 0`, `tmo_err = 0`, `served = 0`, `cnt = 0`, state IDLE. Reset during BUSY drops the grant immediately.
- `req` sampled at edge N in IDLE → `gnt` valid after edge N.
- `done` sampled at edge M → `gnt = 0` after M. Earliest next grant is after M+1, so there is one idle cycle between grants.
- Grant length without `done`: exactly TMO cycles of `gnt_valid = 1`. `tmo_err` is high in the first cycle after release.
- Arbitration path is combinational from `req`/`served` into the registered `gnt`. No combinational input-to-output paths.

## Structure
- Shared include/package: state encodings (`ST_IDLE = 1'b0`, `ST_BUSY = 1'b1`).
- The one-hot→binary encoder is a function in the same package, reused by other bitops blocks.
- Sub-module: one `bitops_get_hi` instance (`width = WIDTH`) computing `win` from `cand`. All sequencing stays in this block.

## Test plan
- Reset: hold `rst_n = 0` with `req = 8'hFF` → all outputs 0. After release, the first grant is `gnt = 8'h80`, `gnt_idx = 7`, one cycle after the first sampled edge.
- Basic: `req = 8'b0010_0100` → `gnt = 8'b0010_0000`, idx 5. Pulse `done` → `gnt = 0` next cycle, then `gnt = 8'b0000_0100`, idx 2, one cycle later.
- Fairness: `req = 8'hFF` held, `done` pulsed 1 cycle after each grant → idx sequence 7,6,5,4,3,2,1,0,7 (round restarts, `served = 8'h80`).
- Late joiner: `req = 8'h81`; after idx 7 is served, raise bit 7 again and add bit 4 → next grants are 4, then 0, then new round at 7.
- Watchdog: grant idx 3, no `done` → `gnt_valid` high exactly 16 cycles, `tmo_err` pulses once. `done` on cycle 16 instead → no `tmo_err`.
- Withdrawal/reset: drop `req` during BUSY → `gnt` held until `done`. Assert `rst_n = 0` mid-BUSY → `gnt = 0` immediately, `served = 0`.
